// File: rtl/sh7604_ibus_arb_if.sv
// Requester-side and BSC-side signals of the SH7604 internal bus arbiter.
// Latency: none, signal bundle only. Backpressure: the per-requester BUSY lines stall each requester.
// The arbiter uses the slave modport; the requesters and the BSC use the master modport.
interface sh7604_ibus_arb_if;
    logic        C_REQ;
    logic        D_REQ;
    logic        V_REQ;
    logic [31:0] C_A;
    logic [31:0] D_A;
    logic [3:0]  V_A;
    logic [31:0] C_DO;
    logic [31:0] D_DO;
    logic [3:0]  C_BA;
    logic [3:0]  D_BA;
    logic        C_WE;
    logic        D_WE;
    logic        C_LOCK;
    logic        D_LOCK;
    logic        C_BURST;
    logic        D_BURST;
    logic        C_BUSY;
    logic        D_BUSY;
    logic        V_BUSY;
    logic [1:0]  GNT;
    logic        M_REQ;
    logic [31:0] M_A;
    logic [31:0] M_DO;
    logic [3:0]  M_BA;
    logic        M_WE;
    logic        M_LOCK;
    logic        M_BURST;
    logic        M_ACK;

    modport slave (
        input  C_REQ, D_REQ, V_REQ, C_A, D_A, V_A, C_DO, D_DO, C_BA, D_BA,
        input  C_WE, D_WE, C_LOCK, D_LOCK, C_BURST, D_BURST, M_ACK,
        output C_BUSY, D_BUSY, V_BUSY, GNT, M_REQ, M_A, M_DO, M_BA,
        output M_WE, M_LOCK, M_BURST
    );

    modport master (
        output C_REQ, D_REQ, V_REQ, C_A, D_A, V_A, C_DO, D_DO, C_BA, D_BA,
        output C_WE, D_WE, C_LOCK, D_LOCK, C_BURST, D_BURST, M_ACK,
        input  C_BUSY, D_BUSY, V_BUSY, GNT, M_REQ, M_A, M_DO, M_BA,
        input  M_WE, M_LOCK, M_BURST
    );
endinterface

// File: rtl/sh7604_ibus_arb.sv
// Fixed-priority (V > D > C) BSC master-port arbiter with a DMA starvation guard and LOCK/BURST hold.
// Latency: a request seen in cycle n is granted in cycle n+1; on release the next owner follows with no bubble.
// Backpressure: every requester's BUSY stays high until the BSC acks that requester's own transfer.
module sh7604_ibus_arb #(
    parameter int DMA_RUN_MAX = 4,
    parameter int BURST_MAX   = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             EN,
    input  logic             RES_N,
    sh7604_ibus_arb_if.slave bus
);

    localparam int RW = $clog2(DMA_RUN_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [RW-1:0] RUN_SAT  = RW'(DMA_RUN_MAX);
    localparam logic [BW-1:0] BEAT_SAT = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2,
        OWN_V = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [RW-1:0]  run_cnt;
    logic [RW-1:0]  run_nxt;
    logic [BW-1:0]  beat_cnt;
    logic [BW-1:0]  beat_nxt;

    logic own_req;
    logic own_lock;
    logic own_burst;
    logic ack;
    logic keep;
    logic v_cand;
    logic d_cand;
    logic c_cand;

    // When starve is set, a waiting C beats D. V always wins.
    function automatic state_t pick(input logic v, input logic d, input logic c, input logic starve);
        state_t s;
        s = IDLE;
        if (v) begin
            s = OWN_V;
        end else if (d && !(c && starve)) begin
            s = OWN_D;
        end else if (c) begin
            s = OWN_C;
        end
        return s;
    endfunction

    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_burst = 1'b0;
        case (state)
            OWN_C: begin
                own_req   = bus.C_REQ;
                own_lock  = bus.C_LOCK;
                own_burst = bus.C_BURST;
            end
            OWN_D: begin
                own_req   = bus.D_REQ;
                own_lock  = bus.D_LOCK;
                own_burst = bus.D_BURST;
            end
            OWN_V: begin
                own_req   = bus.V_REQ;
            end
            default: begin
            end
        endcase
    end

    assign ack  = bus.M_ACK && own_req;
    assign keep = own_lock || (own_burst && (beat_cnt < BEAT_SAT - 1'b1));

    always_comb begin
        run_nxt = run_cnt;
        if (!bus.C_REQ) begin
            run_nxt = '0;
        end else if (ack && state == OWN_C) begin
            run_nxt = '0;
        end else if (ack && state == OWN_D && run_cnt != RUN_SAT) begin
            run_nxt = run_cnt + 1'b1;
        end
    end

    // V and C step aside for another pending requester when they release.
    // D stays eligible: RUN_CNT is what bounds its run against C.
    always_comb begin
        v_cand = bus.V_REQ;
        d_cand = bus.D_REQ;
        c_cand = bus.C_REQ;
        if (state == OWN_V && (bus.D_REQ || bus.C_REQ)) begin
            v_cand = 1'b0;
        end
        if (state == OWN_C && (bus.V_REQ || bus.D_REQ)) begin
            c_cand = 1'b0;
        end
    end

    // An owner without REQ holds a stale zero-bubble re-grant; re-arbitrate at once.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        if (state == IDLE || !own_req) begin
            state_nxt = pick(bus.V_REQ, bus.D_REQ, bus.C_REQ, run_cnt == RUN_SAT);
            beat_nxt  = '0;
        end else if (ack) begin
            if (keep) begin
                beat_nxt = (beat_cnt == BEAT_SAT) ? beat_cnt : beat_cnt + 1'b1;
            end else begin
                beat_nxt  = '0;
                state_nxt = pick(v_cand, d_cand, c_cand, run_nxt == RUN_SAT);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            run_cnt  <= '0;
            beat_cnt <= '0;
        end else if (CE_R) begin
            if (!RES_N) begin
                state    <= IDLE;
                run_cnt  <= '0;
                beat_cnt <= '0;
            end else if (EN) begin
                state    <= state_nxt;
                run_cnt  <= run_nxt;
                beat_cnt <= beat_nxt;
            end
        end
    end

    always_comb begin
        bus.GNT     = state;
        bus.M_REQ   = own_req;
        bus.M_A     = '0;
        bus.M_DO    = '0;
        bus.M_BA    = '0;
        bus.M_WE    = 1'b0;
        bus.M_LOCK  = 1'b0;
        bus.M_BURST = 1'b0;
        case (state)
            OWN_C: begin
                bus.M_A     = bus.C_A;
                bus.M_DO    = bus.C_DO;
                bus.M_BA    = bus.C_BA;
                bus.M_WE    = bus.C_WE;
                bus.M_LOCK  = bus.C_LOCK;
                bus.M_BURST = bus.C_BURST;
            end
            OWN_D: begin
                bus.M_A     = bus.D_A;
                bus.M_DO    = bus.D_DO;
                bus.M_BA    = bus.D_BA;
                bus.M_WE    = bus.D_WE;
                bus.M_LOCK  = bus.D_LOCK;
                bus.M_BURST = bus.D_BURST;
            end
            OWN_V: begin
                bus.M_A  = {28'h0, bus.V_A};
                bus.M_BA = 4'b0001;
            end
            default: begin
            end
        endcase
    end

    assign bus.C_BUSY = bus.C_REQ && !(state == OWN_C && bus.M_ACK);
    assign bus.D_BUSY = bus.D_REQ && !(state == OWN_D && bus.M_ACK);
    assign bus.V_BUSY = bus.V_REQ && !(state == OWN_V && bus.M_ACK);

    // An owner that is still waiting for its ack must keep REQ up, unless a soft reset abandons the transfer.
    logic chk_hold;
    assign chk_hold = CE_R && EN && RES_N && (state != IDLE) && own_req && !bus.M_ACK;

    a_owner_req_held: assert property (@(posedge CLK) disable iff (!RST_N)
        $past(chk_hold) |-> (own_req || !RES_N));

endmodule
